// File: rtl/ram_port_arbiter_if.sv
// Per-requester request/response channel between a CPU-side port and ram_port_arbiter.
// master = requester side, slave = arbiter side.
interface ram_port_arbiter_if #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin two-port sequencer for a single-port synchronous 2048x64 RAM.
// Define RAM_ARB_PERF_EN to add saturating per-port grant counters.
module ram_port_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 64
`ifdef RAM_ARB_PERF_EN
    ,
    parameter int unsigned CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              reset,
    ram_port_arbiter_if.slave p0,
    ram_port_arbiter_if.slave p1,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_is_reading,
    // The RAM's [0:DATA_W-1] bus maps MSB-to-MSB onto this vector, so values pass unchanged.
    inout  wire  [DATA_W-1:0] ram_data
`ifdef RAM_ARB_PERF_EN
    ,
    output logic [CNT_W-1:0]  p0_grant_count,
    output logic [CNT_W-1:0]  p1_grant_count
`endif
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_q;      // 1: p1 was granted last, so p0 wins the next tie
    logic              owner_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              grant0;
    logic              grant1;
    logic              wr_issue;

    always_comb begin
        state_d = state_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            StIdle: begin
                grant0 = p0.req_valid && (!p1.req_valid || last_q);
                grant1 = p1.req_valid && (!p0.req_valid || !last_q);
                if (grant0 || grant1) state_d = StIssue;
            end
            StIssue: state_d = write_q ? StResp : StWait;
            StWait:  state_d = StResp;
            StResp: begin
                if (owner_q ? p1.rsp_ready : p0.rsp_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign wr_issue = (state_q == StIssue) && write_q;

    assign p0.req_ready = grant0;
    assign p1.req_ready = grant1;
    assign p0.rsp_valid = (state_q == StResp) && !owner_q;
    assign p1.rsp_valid = (state_q == StResp) && owner_q;
    assign p0.rsp_rdata = rdata0_q;
    assign p1.rsp_rdata = rdata1_q;

    // The RAM writes on every edge with isReading low, so it is dropped only for a write issue.
    assign ram_address    = addr_q;
    assign ram_is_reading = !wr_issue;
    assign ram_data       = wr_issue ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant0 || grant1) begin
                owner_q <= grant1;
                last_q  <= grant1;
                write_q <= grant1 ? p1.req_write : p0.req_write;
                addr_q  <= grant1 ? p1.req_addr  : p0.req_addr;
                wdata_q <= grant1 ? p1.req_wdata : p0.req_wdata;
            end
            if (wr_issue) begin
                if (owner_q) rdata1_q <= '0;
                else         rdata0_q <= '0;
            end
            // RAM output is valid during the cycle after the read was issued.
            if (state_q == StWait) begin
                if (owner_q) rdata1_q <= ram_data;
                else         rdata0_q <= ram_data;
            end
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant0 && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
            if (grant1 && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign p0_grant_count = cnt0_q;
    assign p1_grant_count = cnt1_q;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: behavioural RAM, transaction-level reference model,
// directed scenarios followed by random traffic.
module tb_ram_port_arbiter;
    localparam int unsigned AW = 11;
    localparam int unsigned DW = 64;
`ifdef RAM_ARB_PERF_EN
    localparam int unsigned CW = 2;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();

    logic [AW-1:0] ram_address;
    logic          ram_is_reading;
    wire  [DW-1:0] ram_data;
`ifdef RAM_ARB_PERF_EN
    logic [CW-1:0] gc0;
    logic [CW-1:0] gc1;
`endif

    ram_port_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW)
`ifdef RAM_ARB_PERF_EN
        ,
        .CNT_W(CW)
`endif
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .p0            (p0_if),
        .p1            (p1_if),
        .ram_address   (ram_address),
        .ram_is_reading(ram_is_reading),
        .ram_data      (ram_data)
`ifdef RAM_ARB_PERF_EN
        ,
        .p0_grant_count(gc0),
        .p1_grant_count(gc1)
`endif
    );

    // Behavioural single-port synchronous RAM.
    logic [DW-1:0] ram_mem [0:2047];
    logic [DW-1:0] ram_rd_q;
    logic          ram_clr;
    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 2048; i++) ram_mem[i] <= '0;
            ram_rd_q <= '0;
        end else if (ram_is_reading) begin
            ram_rd_q <= ram_mem[ram_address];
        end else begin
            ram_mem[ram_address] <= ram_data;
        end
    end
    assign ram_data = ram_is_reading ? ram_rd_q : 'z;

    // Pin-level drive, updated only at negedge.
    logic          d_v [2];
    logic          d_w [2];
    logic [AW-1:0] d_a [2];
    logic [DW-1:0] d_d [2];
    logic          d_rr[2];
    assign p0_if.req_valid = d_v[0];
    assign p0_if.req_write = d_w[0];
    assign p0_if.req_addr  = d_a[0];
    assign p0_if.req_wdata = d_d[0];
    assign p0_if.rsp_ready = d_rr[0];
    assign p1_if.req_valid = d_v[1];
    assign p1_if.req_write = d_w[1];
    assign p1_if.req_addr  = d_a[1];
    assign p1_if.req_wdata = d_d[1];
    assign p1_if.rsp_ready = d_rr[1];

    logic          g_ready [2];
    logic          g_rvalid[2];
    logic [DW-1:0] g_rdata [2];
    assign g_ready[0]  = p0_if.req_ready;
    assign g_ready[1]  = p1_if.req_ready;
    assign g_rvalid[0] = p0_if.rsp_valid;
    assign g_rvalid[1] = p1_if.rsp_valid;
    assign g_rdata[0]  = p0_if.rsp_rdata;
    assign g_rdata[1]  = p1_if.rsp_rdata;

    // Requests the bench wants to present, and reference-model state.
    bit            rq_v [2];
    bit            rq_w [2];
    logic [AW-1:0] rq_a [2];
    logic [DW-1:0] rq_d [2];
    bit            rq_rr[2];
    logic [DW-1:0] ref_mem [0:2047];
    bit            busy;
    int            owner, age, lat, last;
    bit            cur_wr;
    logic [AW-1:0] cur_addr, exp_addr;
    logic [DW-1:0] cur_data, exp_rdata;
    int            grants[2];
    int            glog[$];
    bit            rand_mode;
    int            checks, errors;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic req(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        rq_v[p] = 1'b1;
        rq_w[p] = w;
        rq_a[p] = a;
        rq_d[p] = d;
    endtask

    // One clock cycle: drive at negedge, check just after, then advance the model.
    task automatic step();
        bit er[2];
        bit ev, issue;
        int p;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (rand_mode && !rq_v[i] && ($urandom_range(0, 2) == 0))
                req(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), {$urandom, $urandom});
            if (rand_mode) rq_rr[i] = ($urandom_range(0, 3) != 0);
            d_v[i]  = rq_v[i];
            d_rr[i] = rq_rr[i];
            if (rq_v[i]) begin
                d_w[i] = rq_w[i];
                d_a[i] = rq_a[i];
                d_d[i] = rq_d[i];
            end else begin
                d_w[i] = 1'($urandom_range(0, 1));
                d_a[i] = AW'($urandom);
                d_d[i] = {$urandom, $urandom};
            end
        end
        #1;
        er[0] = !busy && rq_v[0] && (!rq_v[1] || last == 1);
        er[1] = !busy && rq_v[1] && (!rq_v[0] || last == 0);
        issue = busy && (age == 1);
        for (int i = 0; i < 2; i++) begin
            ev = busy && (owner == i) && (age >= lat);
            chk($sformatf("p%0d_req_ready", i), 64'(g_ready[i]), 64'(er[i]));
            chk($sformatf("p%0d_rsp_valid", i), 64'(g_rvalid[i]), 64'(ev));
            if (ev) chk($sformatf("p%0d_rsp_rdata", i), g_rdata[i], exp_rdata);
        end
        chk("ram_is_reading", 64'(ram_is_reading), 64'(!(issue && cur_wr)));
        chk("ram_address", 64'(ram_address), 64'(exp_addr));
        if (issue && cur_wr) chk("ram_data_write", ram_data, cur_data);
`ifdef RAM_ARB_PERF_EN
        chk("p0_grant_count", 64'(gc0), 64'(grants[0] > 3 ? 3 : grants[0]));
        chk("p1_grant_count", 64'(gc1), 64'(grants[1] > 3 ? 3 : grants[1]));
`endif
        if (busy) begin
            if ((age >= lat) && rq_rr[owner]) busy = 1'b0;
            else age++;
        end else if (er[0] || er[1]) begin
            p         = er[1] ? 1 : 0;
            busy      = 1'b1;
            age       = 1;
            owner     = p;
            cur_wr    = rq_w[p];
            cur_addr  = rq_a[p];
            cur_data  = rq_d[p];
            lat       = cur_wr ? 2 : 3;
            exp_rdata = cur_wr ? '0 : ref_mem[cur_addr];
            if (cur_wr) ref_mem[cur_addr] = cur_data;
            last      = p;
            exp_addr  = cur_addr;
            grants[p]++;
            glog.push_back(p);
            rq_v[p]   = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (busy || rq_v[0] || rq_v[1]); i++) step();
        chk("drain_done", 64'(busy || rq_v[0] || rq_v[1]), 64'(0));
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_v[i]  = 1'b0;
            d_rr[i] = 1'b0;
            rq_v[i] = 1'b0;
        end
        repeat (n) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_p0_rsp_valid", 64'(g_rvalid[0]), 64'(0));
        chk("rst_p1_rsp_valid", 64'(g_rvalid[1]), 64'(0));
        chk("rst_p0_rsp_rdata", g_rdata[0], 64'(0));
        chk("rst_p1_rsp_rdata", g_rdata[1], 64'(0));
        chk("rst_ram_is_reading", 64'(ram_is_reading), 64'(1));
        chk("rst_ram_address", 64'(ram_address), 64'(0));
`ifdef RAM_ARB_PERF_EN
        chk("rst_p0_grant_count", 64'(gc0), 64'(0));
        chk("rst_p1_grant_count", 64'(gc1), 64'(0));
`endif
        busy      = 1'b0;
        last      = 1;
        exp_addr  = '0;
        grants[0] = 0;
        grants[1] = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rand_mode = 1'b0;
        reset = 1'b1;
        ram_clr = 1'b1;
        for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
        for (int i = 0; i < 2; i++) begin
            d_v[i] = 1'b0; d_w[i] = 1'b0; d_a[i] = '0; d_d[i] = '0; d_rr[i] = 1'b0;
            rq_v[i] = 1'b0; rq_w[i] = 1'b0; rq_a[i] = '0; rq_d[i] = '0; rq_rr[i] = 1'b1;
        end
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;
        do_reset(2);

        // Idle after reset, then untouched addresses read back as zero.
        repeat (20) step();
        for (int a = 0; a < 8; a++) begin
            req(0, 1'b0, AW'(a), '0);
            drain();
        end

        // Write then read back on p0; latency is checked cycle by cycle in step().
        req(0, 1'b1, 11'h005, 64'hDEAD_BEEF_0123_4567);
        drain();
        req(0, 1'b0, 11'h005, '0);
        drain();

        // p1 response back-pressured for 5 cycles while p0 waits.
        rq_rr[1] = 1'b0;
        req(1, 1'b0, 11'h005, '0);
        req(0, 1'b0, 11'h006, '0);
        for (int i = 0; i < 10 && !(busy && age >= lat); i++) step();
        chk("t4_rsp_pending", 64'(busy && age >= lat), 64'(1));
        chk("t4_owner", 64'(owner), 64'(1));
        repeat (5) step();
        rq_rr[1] = 1'b1;
        drain();
        chk("t4_p0_after_pop", 64'(glog[$]), 64'(0));

        // Reset during the WAIT cycle of a read discards it.
        req(0, 1'b0, 11'h005, '0);
        for (int i = 0; i < 10 && !(busy && age == 2); i++) step();
        chk("t5_in_wait", 64'(busy && age == 2), 64'(1));
        do_reset(1);
        repeat (3) step();

        // Both ports hold reads: grants must alternate starting with p0.
        glog.delete();
        for (int i = 0; i < 60 && glog.size() < 4; i++) begin
            if (!rq_v[0]) req(0, 1'b0, 11'h005, '0);
            if (!rq_v[1]) req(1, 1'b0, 11'h006, '0);
            step();
        end
        rq_v[0] = 1'b0;
        rq_v[1] = 1'b0;
        drain();
        chk("t2_grant_total", 64'(glog.size()), 64'(4));
        if (glog.size() == 4)
            for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), 64'(glog[i]), 64'(i % 2));

        // Random traffic against the reference model.
        rand_mode = 1'b1;
        repeat (400) step();
        rand_mode = 1'b0;
        rq_rr[0] = 1'b1;
        rq_rr[1] = 1'b1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
